// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: I2S master transmitter. It takes one signed accumulator result per
// channel, rounds and saturates each one to DATA_BITS-wide PCM, holds the pair until the
// next frame boundary, and shifts them out MSB first. The data follows the word-select
// edge by one bit, as the standard I2S format requires.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   audio_en                1 = transmit, 0 = return to idle and discard state
//   l_audio_in, r_audio_in  signed ACC_BITS accumulator results
//   sample_valid            1-cycle strobe that captures both channels
//   frame_req               pulse when a frame is loaded (the holding register is free)
//   underrun                pulse when a frame is loaded with no sample pending
//   overrun                 pulse when a pending sample is overwritten
//   clip                    pulse when either channel saturated at capture
//   i2s_bclk, i2s_lrclk,    serial bit clock, word select (0 = left), and data
//   i2s_sdata
module i2s_tx_serializer #(
    parameter int unsigned CLK_PER_HALF = 4,
    parameter int unsigned SLOT_BITS    = 32,
    parameter int unsigned DATA_BITS    = 24,
    parameter int unsigned ACC_BITS     = 48,
    parameter int unsigned FRAC_SHIFT   = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                audio_en,
    input  logic [ACC_BITS-1:0] l_audio_in,
    input  logic [ACC_BITS-1:0] r_audio_in,
    input  logic                sample_valid,
    output logic                frame_req,
    output logic                underrun,
    output logic                overrun,
    output logic                clip,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned CNT_BITS   = $clog2(FRAME_BITS);
    localparam int unsigned DIV_BITS   = $clog2(CLK_PER_HALF);
    localparam int unsigned EXT_BITS   = ACC_BITS + 1;
    localparam int unsigned Y_BITS     = EXT_BITS - FRAC_SHIFT;
    localparam int unsigned TOP_BITS   = Y_BITS - DATA_BITS + 1;
    localparam int unsigned SR_BITS    = 2 * DATA_BITS;
    localparam logic [EXT_BITS-1:0] HALF_LSB = EXT_BITS'(1) << (FRAC_SHIFT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t               state;
    logic [DIV_BITS-1:0]  div;
    logic [CNT_BITS-1:0]  bit_cnt;
    logic [DATA_BITS-1:0] hold_l;
    logic [DATA_BITS-1:0] hold_r;
    logic                 pend;
    logic [SR_BITS-1:0]   shift_reg;

    // Round half up, then arithmetic shift. The accumulator gets one guard bit, so adding
    // the rounding constant cannot wrap. Returns {clipped, pcm}.
    function automatic logic [DATA_BITS:0] round_sat(input logic [ACC_BITS-1:0] x);
        logic [EXT_BITS-1:0] sum;
        logic [Y_BITS-1:0]   y;
        logic [TOP_BITS-1:0] top;
        logic                ovf;
        sum = {x[ACC_BITS-1], x} + HALF_LSB;
        y   = sum[EXT_BITS-1:FRAC_SHIFT];
        // The result fits in PCM only when every bit above the PCM sign bit copies that sign bit.
        top = y[Y_BITS-1:DATA_BITS-1];
        ovf = !((&top) || !(|top));
        if (!ovf) begin
            return {1'b0, y[DATA_BITS-1:0]};
        end else if (y[Y_BITS-1]) begin
            return {1'b1, 1'b1, {(DATA_BITS - 1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(DATA_BITS - 1){1'b1}}};
        end
    endfunction

    logic [DATA_BITS:0]  l_conv_c;
    logic [DATA_BITS:0]  r_conv_c;
    logic [CNT_BITS-1:0] next_cnt_c;
    logic [CNT_BITS-1:0] slot_bit_c;
    logic                next_lr_c;
    logic                data_bit_c;
    logic                bclk_fall_c;
    logic                frame_load_c;

    assign l_conv_c = round_sat(l_audio_in);
    assign r_conv_c = round_sat(r_audio_in);

    // Bit position after the next falling edge; it decides word select, data, and frame load.
    always_comb begin
        next_cnt_c   = (bit_cnt == CNT_BITS'(FRAME_BITS - 1)) ? '0 : bit_cnt + CNT_BITS'(1);
        next_lr_c    = (next_cnt_c >= CNT_BITS'(SLOT_BITS));
        slot_bit_c   = next_lr_c ? next_cnt_c - CNT_BITS'(SLOT_BITS) : next_cnt_c;
        data_bit_c   = (slot_bit_c != '0) && (slot_bit_c <= CNT_BITS'(DATA_BITS));
        bclk_fall_c  = (div == DIV_BITS'(CLK_PER_HALF - 1)) && i2s_bclk;
        frame_load_c = bclk_fall_c && (next_cnt_c == '0);
    end

    // Control FSM, bit-clock divider, serializer and holding register.
    always_ff @(posedge clk) begin
        frame_req <= 1'b0;
        underrun  <= 1'b0;
        overrun   <= 1'b0;
        clip      <= 1'b0;
        if (reset || (state == ST_RUN && !audio_en)) begin
            state     <= ST_IDLE;
            div       <= '0;
            bit_cnt   <= CNT_BITS'(FRAME_BITS - 1);
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b1;
            i2s_sdata <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            pend      <= 1'b0;
            shift_reg <= '0;
        end else if (state == ST_IDLE) begin
            if (audio_en) begin
                state <= ST_RUN;
            end
        end else begin
            if (div == DIV_BITS'(CLK_PER_HALF - 1)) begin
                div      <= '0;
                i2s_bclk <= ~i2s_bclk;
            end else begin
                div <= div + DIV_BITS'(1);
            end

            // Data changes on the falling edge, so the DAC samples it on the rising edge.
            if (bclk_fall_c) begin
                bit_cnt   <= next_cnt_c;
                i2s_lrclk <= next_lr_c;
                if (frame_load_c) begin
                    frame_req <= 1'b1;
                    i2s_sdata <= 1'b0;
                    if (pend) begin
                        shift_reg <= {hold_l, hold_r};
                    end else begin
                        shift_reg <= '0;
                        underrun  <= 1'b1;
                    end
                end else if (data_bit_c) begin
                    i2s_sdata <= shift_reg[SR_BITS-1];
                    shift_reg <= {shift_reg[SR_BITS-2:0], 1'b0};
                end else begin
                    i2s_sdata <= 1'b0;
                end
            end

            // A frame load reads the old holding contents, so a capture in the same cycle
            // is kept for the next frame.
            if (sample_valid) begin
                hold_l  <= l_conv_c[DATA_BITS-1:0];
                hold_r  <= r_conv_c[DATA_BITS-1:0];
                pend    <= 1'b1;
                clip    <= l_conv_c[DATA_BITS] | r_conv_c[DATA_BITS];
                overrun <= pend && !frame_load_c;
            end else if (frame_load_c) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Testbench for i2s_tx_serializer. A frame-level reference model predicts every output on
// every cycle, and the stimulus is directed steps followed by random frames.
module tb_i2s_tx_serializer;

    localparam int CPH        = 4;
    localparam int SLOT       = 32;
    localparam int DB         = 24;
    localparam int AB         = 48;
    localparam int FS         = 15;
    localparam int FRAME_CYC  = 4 * SLOT * CPH;
    localparam int FIRST_FALL = 2 * CPH;

    logic          clk = 1'b0;
    logic          reset;
    logic          audio_en;
    logic [AB-1:0] l_in;
    logic [AB-1:0] r_in;
    logic          sample_valid;
    logic          frame_req, underrun, overrun, clip;
    logic          bclk, lrclk, sdata;

    always #5 clk = ~clk;

    i2s_tx_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .audio_en    (audio_en),
        .l_audio_in  (l_in),
        .r_audio_in  (r_in),
        .sample_valid(sample_valid),
        .frame_req   (frame_req),
        .underrun    (underrun),
        .overrun     (overrun),
        .clip        (clip),
        .i2s_bclk    (bclk),
        .i2s_lrclk   (lrclk),
        .i2s_sdata   (sdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: c counts the enabled clocks since RUN was entered.
    bit              m_run = 1'b0;
    int              c = 0;
    bit              m_pend = 1'b0;
    logic [DB-1:0]   m_hl = '0;
    logic [DB-1:0]   m_hr = '0;
    logic [2*DB-1:0] frames[$];
    bit              e_req, e_und, e_ovr, e_clip;

    // Rounds and clamps the accumulator value with plain 64-bit signed arithmetic.
    function automatic logic [DB:0] ref_conv(input logic [AB-1:0] x);
        longint        v, y, hi, lo;
        bit            cl;
        logic [DB-1:0] w;
        v  = longint'($signed(x));
        y  = (v + (longint'(1) << (FS - 1))) >>> FS;
        hi = (longint'(1) << (DB - 1)) - 1;
        lo = -(longint'(1) << (DB - 1));
        cl = (y > hi) || (y < lo);
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        w = DB'(y);
        return {cl, w};
    endfunction

    function automatic logic [AB-1:0] rnd48();
        logic signed [63:0] t;
        t = $signed({$urandom, $urandom});
        t = t >>> $urandom_range(16, 40);
        return t[AB-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (run cycle %0d)", tag, obs, exp_v, c);
        end
    endtask

    // Applies the rules at one clock edge to the inputs that were present at that edge.
    task automatic model_edge();
        logic [DB:0] lc, rc;
        bit          load;
        e_req = 0; e_und = 0; e_ovr = 0; e_clip = 0;
        if (reset) begin
            m_run = 0; m_pend = 0; m_hl = '0; m_hr = '0;
        end else if (!m_run) begin
            if (audio_en) begin
                m_run = 1; c = 0; frames.delete();
            end
        end else if (!audio_en) begin
            m_run = 0; m_pend = 0; m_hl = '0; m_hr = '0;
        end else begin
            c++;
            load = (c >= FIRST_FALL) && ((c - FIRST_FALL) % FRAME_CYC == 0);
            if (load) begin
                e_req = 1;
                if (m_pend) frames.push_back({m_hl, m_hr});
                else begin
                    frames.push_back('0);
                    e_und = 1;
                end
                m_pend = 0;
            end
            if (sample_valid) begin
                lc = ref_conv(l_in);
                rc = ref_conv(r_in);
                e_ovr  = m_pend;
                e_clip = lc[DB] | rc[DB];
                m_hl = lc[DB-1:0];
                m_hr = rc[DB-1:0];
                m_pend = 1;
            end
        end
    endtask

    // Works out the expected waveform from the position within the frame.
    task automatic check_outputs();
        logic            eb, el, es;
        int              n, b, k, f;
        logic [DB-1:0]   w;
        logic [2*DB-1:0] fr;
        eb = 0; el = 1; es = 0;
        if (m_run) begin
            eb = ((c / CPH) % 2) == 1;
            n  = c / (2 * CPH);
            if (n >= 1) begin
                b  = (n - 1) % (2 * SLOT);
                f  = (n - 1) / (2 * SLOT);
                el = (b >= SLOT);
                k  = b % SLOT;
                fr = (f < frames.size()) ? frames[f] : '0;
                w  = el ? fr[DB-1:0] : fr[2*DB-1:DB];
                es = (k >= 1 && k <= DB) ? w[DB-k] : 1'b0;
            end
        end
        chk("bclk", 64'(bclk), 64'(eb));
        chk("lrclk", 64'(lrclk), 64'(el));
        chk("sdata", 64'(sdata), 64'(es));
        chk("frame_req", 64'(frame_req), 64'(e_req));
        chk("underrun", 64'(underrun), 64'(e_und));
        chk("overrun", 64'(overrun), 64'(e_ovr));
        chk("clip", 64'(clip), 64'(e_clip));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic strobe(input logic [AB-1:0] l, input logic [AB-1:0] r);
        sample_valid = 1'b1;
        l_in = l;
        r_in = r;
        cyc();
        sample_valid = 1'b0;
        l_in = rnd48();
        r_in = rnd48();
    endtask

    // Stops one clock before a frame-load edge, so the next strobe coincides with the load.
    task automatic to_pre_load();
        for (int i = 0; i < FRAME_CYC + FIRST_FALL; i++) begin
            if (((c + 1 - FIRST_FALL) % FRAME_CYC) == 0) break;
            cyc();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; audio_en = 1'b0; sample_valid = 1'b0; l_in = '0; r_in = '0;

        // Reset with strobes applied: the outputs stay at idle values and nothing is captured.
        for (int i = 0; i < 3; i++) begin
            sample_valid = i[0];
            l_in = 48'h7FFF_FFFF_FFFF;
            cyc();
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_valid = ~i[0];
            l_in = 48'h8000_0000_0000;
            cyc();
        end
        sample_valid = 1'b0;

        // Basic frame: the left slot carries 0x123456 and the right slot 0xFFFFFE.
        audio_en = 1'b1;
        cyc();
        strobe(48'(64'h123456 << 15), 48'(-64'sd2 <<< 15));
        run(FRAME_CYC + 40);

        // Rounding cases around half an LSB.
        strobe(48'h4000, 48'h3FFF);
        run(FRAME_CYC);
        strobe(48'(-64'sd16384), 48'(-64'sd16385));
        run(FRAME_CYC);

        // Saturation at both extremes.
        strobe(48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000);
        run(FRAME_CYC);

        // A frame with no strobe sends zeros.
        run(FRAME_CYC);
        // Two strobes in one frame: the second one is sent.
        strobe(48'h1111_2222_3333, 48'h0000_4444_5555);
        run(30);
        strobe(48'h0000_0abc_d000, 48'hFFFF_F000_0000);
        run(FRAME_CYC);
        // A strobe on the load cycle goes to the next frame.
        strobe(48'h0000_1234_5678, 48'h0000_0765_4321);
        to_pre_load();
        strobe(48'hFFFF_FEDC_BA98, 48'h0000_0000_8000);
        run(2 * FRAME_CYC);

        // Random frames with 0, 1 or 2 strobes at random positions.
        for (int fr = 0; fr < 8; fr++) begin
            int ns, p1, p2;
            ns = $urandom_range(0, 2);
            p1 = $urandom_range(0, FRAME_CYC - 1);
            p2 = $urandom_range(0, FRAME_CYC - 1);
            for (int i = 0; i < FRAME_CYC; i++) begin
                sample_valid = (ns >= 1 && i == p1) || (ns == 2 && i == p2);
                l_in = rnd48();
                r_in = rnd48();
                cyc();
            end
            sample_valid = 1'b0;
        end

        // Abort at right-slot bit 10 with a sample pending, then re-enable.
        strobe(48'h0000_3333_3333, 48'h0000_5555_5555);
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            if (c >= FIRST_FALL && (((c / (2 * CPH)) - 1) % (2 * SLOT)) == SLOT + 10) break;
            cyc();
        end
        audio_en = 1'b0;
        cyc();
        run(5);
        strobe(48'h0000_7777_7777, 48'h0000_1111_1111);
        run(3);
        audio_en = 1'b1;
        cyc();
        run(FRAME_CYC + 20);
        strobe(48'h0000_2468_ace0, 48'hFFFF_FFFF_0000);
        run(FRAME_CYC + 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
